// File: rtl/d_cache_wb_pkg.sv
// Shared types and address helpers for the write-back data cache.
// Field helpers take the geometry as arguments so one package serves every parameter set.
package d_cache_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    UNC  = 2'd3
  } state_t;

  function automatic int tag_bits(input int ib, input int ob);
    return 30 - ib - ob;
  endfunction

  function automatic int words(input int ob);
    return 1 << ob;
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int ob);
    return (a >> 2) & ((32'd1 << ob) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int ib, input int ob);
    return (a >> (2 + ob)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ib, input int ob);
    return a >> (2 + ib + ob);
  endfunction

  // Rebuilds a word address; the offset is masked so a single-word line ignores it.
  function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] idx,
                                            input logic [31:0] off, input int ib, input int ob);
    return (tag << (2 + ib + ob)) | (idx << (2 + ob)) | ((off & ((32'd1 << ob) - 32'd1)) << 2);
  endfunction

endpackage

// File: rtl/d_cache_wb_store.sv
// Line storage: valid/dirty bits with synchronous clear, tag RAM, and word-addressed data RAM.
// Reads are asynchronous; one write port addresses a word by line index and word offset.
module d_cache_wb_store
  import d_cache_wb_pkg::*;
#(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2,
  localparam int TW = tag_bits(INDEX_BITS, OFFSET_BITS),
  localparam int OW = (OFFSET_BITS > 0) ? OFFSET_BITS : 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [OW-1:0]         rd_off,
  output logic                  line_valid,
  output logic                  line_dirty,
  output logic [TW-1:0]         line_tag,
  output logic [31:0]           rd_word,
  input  logic                  wr_en,
  input  logic [OW-1:0]         wr_off,
  input  logic [31:0]           wr_word,
  input  logic                  set_dirty,
  input  logic                  clr_dirty,
  input  logic                  set_valid,
  input  logic [TW-1:0]         wr_tag
);

  localparam int NB = 1 << INDEX_BITS;
  localparam int AW = INDEX_BITS + OFFSET_BITS;
  localparam int NW = 1 << AW;

  logic [NB-1:0] valid_q;
  logic [NB-1:0] dirty_q;
  logic [TW-1:0] tag_q  [NB];
  logic [31:0]   data_q [NW];
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;

  // The shift drops the padding offset bit when a line holds a single word.
  assign rd_addr = AW'({idx, rd_off} >> (OW - OFFSET_BITS));
  assign wr_addr = AW'({idx, wr_off} >> (OW - OFFSET_BITS));

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign rd_word    = data_q[rd_addr];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (set_valid) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (set_dirty) begin
      dirty_q[idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (set_valid) tag_q[idx] <= wr_tag;
    if (wr_en) data_q[wr_addr] <= wr_word;
  end

endmodule

// File: rtl/d_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with an uncached bypass.
// The FSM sequences dirty-victim write-back and line fill one memory word at a time.
module d_cache_wb
  import d_cache_wb_pkg::*;
#(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] p_a,
  input  logic [31:0] p_dout,
  output logic [31:0] p_din,
  input  logic        p_strobe,
  input  logic        p_rw,
  input  logic        uncached,
  output logic        p_ready,
  output logic [31:0] m_a,
  input  logic [31:0] m_dout,
  output logic [31:0] m_din,
  output logic        m_strobe,
  output logic        m_rw,
  input  logic        m_ready,
  output state_t      dbg_state
);

  localparam int TAG_BITS = tag_bits(INDEX_BITS, OFFSET_BITS);
  localparam int OW       = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam int W        = words(OFFSET_BITS);
  localparam logic [OW-1:0] CNT_LAST = OW'(W - 1);

  // Handshakes: a CPU request (p_strobe with p_a/p_rw/p_dout) is held until the cycle
  // p_ready = 1 and completes at that posedge; a memory word (m_strobe with m_a/m_rw/m_din)
  // is held stable until the cycle m_ready = 1 and transfers at that posedge.

  state_t                state, state_nx;
  logic [OW-1:0]         cnt;
  logic                  cnt_step;
  logic                  last;
  logic [TAG_BITS-1:0]   p_tag;
  logic [INDEX_BITS-1:0] p_idx;
  logic [OW-1:0]         p_off;
  logic                  hit;

  logic                  line_valid, line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           rd_word;
  logic [OW-1:0]         rd_off;
  logic                  wr_en, set_dirty, clr_dirty, set_valid;
  logic [OW-1:0]         wr_off;
  logic [31:0]           wr_word;

  assign p_tag = TAG_BITS'(addr_tag(p_a, INDEX_BITS, OFFSET_BITS));
  assign p_idx = INDEX_BITS'(addr_idx(p_a, INDEX_BITS, OFFSET_BITS));
  assign p_off = OW'(addr_off(p_a, OFFSET_BITS));

  // Write-back streams victim words by cnt; otherwise the CPU offset selects the word.
  assign rd_off    = (state == WB) ? cnt : p_off;
  assign hit       = p_strobe & ~uncached & line_valid & (line_tag == p_tag);
  assign last      = m_ready & (cnt == CNT_LAST);
  assign dbg_state = state;

  d_cache_wb_store #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_store (
    .clk        (clk),
    .clrn       (clrn),
    .idx        (p_idx),
    .rd_off     (rd_off),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .rd_word    (rd_word),
    .wr_en      (wr_en),
    .wr_off     (wr_off),
    .wr_word    (wr_word),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty),
    .set_valid  (set_valid),
    .wr_tag     (p_tag)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (cnt_step) cnt <= last ? '0 : cnt + OW'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    p_ready   = 1'b0;
    p_din     = rd_word;
    m_strobe  = 1'b0;
    m_rw      = 1'b0;
    m_a       = '0;
    m_din     = '0;
    wr_en     = 1'b0;
    wr_off    = p_off;
    wr_word   = p_dout;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    set_valid = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      IDLE: begin
        if (p_strobe) begin
          if (uncached) begin
            state_nx = UNC;
          end else if (hit) begin
            p_ready = 1'b1;
            if (p_rw) begin
              wr_en     = 1'b1;
              set_dirty = 1'b1;
            end
          end else if (line_valid && line_dirty) begin
            state_nx = WB;
          end else begin
            state_nx = FILL;
          end
        end
      end
      WB: begin
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_a      = line_addr(32'(line_tag), 32'(p_idx), 32'(cnt), INDEX_BITS, OFFSET_BITS);
        m_din    = rd_word;
        cnt_step = m_ready;
        if (last) begin
          clr_dirty = 1'b1;
          state_nx  = FILL;
        end
      end
      FILL: begin
        m_strobe = 1'b1;
        m_a      = line_addr(32'(p_tag), 32'(p_idx), 32'(cnt), INDEX_BITS, OFFSET_BITS);
        if (m_ready) begin
          wr_en    = 1'b1;
          wr_off   = cnt;
          wr_word  = m_dout;
          cnt_step = 1'b1;
        end
        if (last) begin
          set_valid = 1'b1;
          state_nx  = IDLE;
        end
      end
      UNC: begin
        m_strobe = 1'b1;
        m_rw     = p_rw;
        m_a      = {p_a[31:2], 2'b00};
        m_din    = p_dout;
        p_din    = m_dout;
        p_ready  = m_ready;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_cache_wb.sv
// Bench for d_cache_wb: directed vector table on the default geometry, hand-written
// write-back / slow-memory / mid-fill-reset sequences, and a single-word-line scoreboard.
`timescale 1ns/1ps
module tb_d_cache_wb;
  import d_cache_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  // default geometry DUT
  logic [31:0] p_a, p_dout, p_din, m_a, m_dout, m_din;
  logic        p_strobe, p_rw, uncached, p_ready, m_strobe, m_rw, m_ready;
  state_t      dbg_state;
  // single-word-line DUT
  logic [31:0] s_p_a, s_p_dout, s_p_din, s_m_a, s_m_dout, s_m_din;
  logic        s_p_strobe, s_p_rw, s_uncached, s_p_ready, s_m_strobe, s_m_rw, s_m_ready;
  state_t      s_dbg_state;

  d_cache_wb dut (
    .clk(clk), .clrn(clrn), .p_a(p_a), .p_dout(p_dout), .p_din(p_din),
    .p_strobe(p_strobe), .p_rw(p_rw), .uncached(uncached), .p_ready(p_ready),
    .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe), .m_rw(m_rw),
    .m_ready(m_ready), .dbg_state(dbg_state)
  );

  d_cache_wb #(.INDEX_BITS(4), .OFFSET_BITS(0)) dut_s (
    .clk(clk), .clrn(clrn), .p_a(s_p_a), .p_dout(s_p_dout), .p_din(s_p_din),
    .p_strobe(s_p_strobe), .p_rw(s_p_rw), .uncached(s_uncached), .p_ready(s_p_ready),
    .m_a(s_m_a), .m_dout(s_m_dout), .m_din(s_m_din), .m_strobe(s_m_strobe), .m_rw(s_m_rw),
    .m_ready(s_m_ready), .dbg_state(s_dbg_state)
  );

  // ---------------- memory models ----------------
  typedef struct { logic rw; logic [31:0] a; logic [31:0] d; } xfer_t;
  xfer_t       log_q[$];
  xfer_t       log_s[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] mem_s [logic [31:0]];
  int          lat = 0;
  int          wait_m = 0;
  int          stable_err = 0;
  logic [31:0] hold_a, hold_d;
  logic        hold_rw;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return {a[31:16], 16'h00A0 + {12'h000, a[5:2]}};
  endfunction

  always @(negedge clk) begin
    m_ready = 1'b0;
    if (clrn && m_strobe) begin
      if (wait_m > 0 && (m_a !== hold_a || m_rw !== hold_rw || (m_rw && m_din !== hold_d)))
        stable_err++;
      hold_a = m_a; hold_rw = m_rw; hold_d = m_din;
      if (wait_m >= lat) begin
        wait_m  = 0;
        m_ready = 1'b1;
        if (m_rw) mem_m[m_a] = m_din;
        else m_dout = mem_m.exists(m_a) ? mem_m[m_a] : mem_default(m_a);
        log_q.push_back('{m_rw, m_a, m_rw ? m_din : m_dout});
      end else begin
        wait_m++;
      end
    end else begin
      wait_m = 0;
    end
  end

  always @(negedge clk) begin
    s_m_ready = 1'b0;
    if (clrn && s_m_strobe) begin
      s_m_ready = 1'b1;
      if (s_m_rw) mem_s[s_m_a] = s_m_din;
      else s_m_dout = mem_s.exists(s_m_a) ? mem_s[s_m_a] : mem_default(s_m_a);
      log_s.push_back('{s_m_rw, s_m_a, s_m_rw ? s_m_din : s_m_dout});
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge.
  task automatic cpu_req(input bit sel, input logic rw, input logic unc, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    rd   = '0;
    if (!sel) begin
      p_strobe = 1'b1; p_rw = rw; uncached = unc; p_a = a; p_dout = wd;
    end else begin
      s_p_strobe = 1'b1; s_p_rw = rw; s_uncached = unc; s_p_a = a; s_p_dout = wd;
    end
    while (!done && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (!sel ? p_ready : s_p_ready) begin
        done = 1'b1;
        rd   = !sel ? p_din : s_p_din;
      end
      @(posedge clk); #1;
    end
    p_strobe = 1'b0; p_rw = 1'b0; uncached = 1'b0;
    s_p_strobe = 1'b0; s_p_rw = 1'b0; s_uncached = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL req_timeout: addr %h got no p_ready within %0d cycles", a, cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rw; logic unc; logic [31:0] a; logic [31:0] wd;
    logic chk_rd; logic [31:0] rd; int cyc; int nx; logic [31:0] a0;
  } vec_t;
  vec_t vt[12];

  logic [31:0] rd;
  int          cyc;
  logic [31:0] exp_q[$];
  logic [31:0] ref_m [logic [31:0]];

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_00A0, 6,  4, 32'h0000_0100};
    vt[1]  = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 32'h0000_00A1, 1,  0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 32'h0,         1,  0, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 32'hDEAD_BEEF, 1,  0, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'h0001_0104, 32'h0,         1'b1, 32'h0001_00A1, 10, 8, 32'h0000_0100};
    vt[5]  = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         1'b1, 32'hDEAD_BEEF, 6,  4, 32'h0000_0100};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_0208, 32'h0000_0055, 1'b0, 32'h0,         6,  4, 32'h0000_0200};
    vt[7]  = '{1'b0, 1'b0, 32'h0000_0208, 32'h0,         1'b1, 32'h0000_0055, 1,  0, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_0300, 32'h0,         1'b1, 32'h0000_00A0, 2,  1, 32'h0000_0300};
    vt[9]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_1234, 1'b0, 32'h0,         2,  1, 32'h0000_0100};
    vt[10] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_00A0, 1,  0, 32'h0};
    vt[11] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_1234, 2,  1, 32'h0000_0100};

    p_strobe = 0; p_rw = 0; uncached = 0; p_a = '0; p_dout = '0;
    s_p_strobe = 0; s_p_rw = 0; s_uncached = 0; s_p_a = '0; s_p_dout = '0;
    m_ready = 0; m_dout = '0; s_m_ready = 0; s_m_dout = '0;

    // reset state, sampled while clrn is still low
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_m_strobe", 32'(m_strobe), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd0);
    check("rst_p_ready", 32'(p_ready), 32'd0);
    check("rst_s_m_strobe", 32'(s_m_strobe), 32'd0);
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;

    // table: hits, clean/dirty misses, uncached bypass
    for (int i = 0; i < 12; i++) begin
      log_q.delete();
      cpu_req(1'b0, vt[i].rw, vt[i].unc, vt[i].a, vt[i].wd, rd, cyc);
      if (vt[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vt[i].cyc));
      check($sformatf("v%0d_xfers", i), 32'(log_q.size()), 32'(vt[i].nx));
      if (vt[i].nx > 0 && log_q.size() > 0)
        check($sformatf("v%0d_first_addr", i), log_q[0].a, vt[i].a0);
    end

    // dirty victim: write-back order and data, then fill of the new tag
    log_q.delete();
    cpu_req(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'hCAFE_0001, rd, cyc);
    check("a_alloc_cycles", 32'(cyc), 32'd6);
    log_q.delete();
    cpu_req(1'b0, 1'b0, 1'b0, 32'h0002_0000, 32'h0, rd, cyc);
    check("a_rdata", rd, 32'h0002_00A0);
    check("a_cycles", 32'(cyc), 32'd10);
    check("a_xfers", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("a%0d_rw", i), 32'(log_q[i].rw), (i < 4) ? 32'd1 : 32'd0);
        check($sformatf("a%0d_addr", i), log_q[i].a,
              (i < 4) ? 32'(i * 4) : 32'h0002_0000 + 32'((i - 4) * 4));
        if (i < 4)
          check($sformatf("a%0d_wdata", i), log_q[i].d,
                (i == 1) ? 32'hCAFE_0001 : 32'h0000_00A0 + 32'(i));
      end
    end

    // slow memory: 3 wait cycles per word on a clean miss
    lat = 3;
    stable_err = 0;
    log_q.delete();
    cpu_req(1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0, rd, cyc);
    check("b_rdata", rd, 32'h0000_00A0);
    check("b_cycles", 32'(cyc), 32'd18);
    check("b_xfers", 32'(log_q.size()), 32'd4);
    check("b_stable_err", 32'(stable_err), 32'd0);
    lat = 0;

    // reset during the second fill word
    p_strobe = 1'b1; p_rw = 1'b0; uncached = 1'b0; p_a = 32'h0000_0700; p_dout = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("c_state_fill", 32'(dbg_state), 32'(FILL));
    clrn = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(negedge clk); #1;
    check("c_state_idle", 32'(dbg_state), 32'(IDLE));
    check("c_m_strobe", 32'(m_strobe), 32'd0);
    p_strobe = 1'b0;
    @(posedge clk); #1;
    log_q.delete();
    cpu_req(1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0, rd, cyc);
    check("c_rdata", rd, 32'h0000_00A0);
    check("c_cycles", 32'(cyc), 32'd6);
    check("c_xfers", 32'(log_q.size()), 32'd4);
    if (log_q.size() > 0) check("c_first_addr", log_q[0].a, 32'h0000_0700);

    // single-word lines: random traffic against a CPU-view reference
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, wd;
      logic        rw;
      a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (rw) ref_m[a] = wd;
      else exp_q.push_back(ref_m.exists(a) ? ref_m[a] : mem_default(a));
      log_s.delete();
      cpu_req(1'b1, rw, 1'b0, a, wd, rd, cyc);
      if (!rw && exp_q.size() > 0) check($sformatf("s%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("s%0d_cycles_legal", i), 32'(cyc == 1 || cyc == 3 || cyc == 4), 32'd1);
      check($sformatf("s%0d_xfers", i), 32'(log_s.size()), (cyc == 1) ? 32'd0 : 32'(cyc - 2));
      if (cyc > 1 && log_s.size() > 0)
        check($sformatf("s%0d_fill_addr", i), log_s[log_s.size() - 1].a, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
